fifo_sync_8x8: RTL and testbench

Single-clock synchronous FIFO, 8 entries × 8 bits, with write/read enables and full, empty, almost-full and almost-empty flags. Buffers a byte stream between a producer and a consumer in the same clock domain. Acts as the top-level FIFO block; memory, pointers and flag logic are internal.

---
 rtl/fifo_sync_8x8.sv | 71 +++++++
 tb/tb_fifo_sync_8x8.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fifo_sync_8x8.sv
// Single-clock 8x8 synchronous FIFO with registered read data and
// full/empty/almost-full/almost-empty flags decoded from the occupancy count.
module fifo_sync_8x8 #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             wr_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable_wr,
  input  logic             enable_rd,
  output logic [WIDTH-1:0] data_out,
  output logic             f_empty,
  output logic             f_full,
  output logic             f_almost_full,
  output logic             f_almost_empty
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              wr_ok;
  logic              rd_ok;

  // Each side is gated only by its own flag, so a full FIFO still reads
  // and an empty FIFO still writes when both enables are high.
  assign wr_ok = enable_wr && !f_full;
  assign rd_ok = enable_rd && !f_empty;

  assign f_empty        = (count == '0);
  assign f_full         = (count == CNT_FULL);
  assign f_almost_full  = (count >= CNT_AF);
  assign f_almost_empty = (count <= CNT_ONE);

  // Storage is not reset: entries are unreachable once the pointers clear.
  always_ff @(posedge wr_clk) begin
    if (wr_ok) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr     <= rptr + PTR_ONE;
        data_out <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync_8x8.sv
// Directed bench for fifo_sync_8x8: a queue holds the written bytes and
// supplies the expected read data and occupancy-derived flags.
module tb_fifo_sync_8x8;

  logic       wr_clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       enable_wr;
  logic       enable_rd;
  logic [7:0] data_out;
  logic       f_empty;
  logic       f_full;
  logic       f_almost_full;
  logic       f_almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q [$];
  logic [7:0] exp_dout = 8'h00;

  fifo_sync_8x8 #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .wr_clk         (wr_clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .enable_wr      (enable_wr),
    .enable_rd      (enable_rd),
    .data_out       (data_out),
    .f_empty        (f_empty),
    .f_full         (f_full),
    .f_almost_full  (f_almost_full),
    .f_almost_empty (f_almost_empty)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " data_out"}, 32'(data_out), 32'(exp_dout));
    check({tag, " f_empty"}, 32'(f_empty), 32'(q.size() == 0));
    check({tag, " f_full"}, 32'(f_full), 32'(q.size() == 8));
    check({tag, " f_almost_full"}, 32'(f_almost_full), 32'(q.size() >= 7));
    check({tag, " f_almost_empty"}, 32'(f_almost_empty), 32'(q.size() <= 1));
  endtask

  // Drive one cycle, update the reference at the edge, then check 1ns later.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [7:0] din);
    bit w;
    bit r;
    enable_wr = wr;
    enable_rd = rd;
    data_in   = din;
    @(posedge wr_clk);
    w = wr && (q.size() < 8);
    r = rd && (q.size() > 0);
    if (r) exp_dout = q.pop_front();
    if (w) q.push_back(din);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] fill_vals [8];
    fill_vals = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hBB, 8'hFF, 8'h07};

    reset_n   = 1'b0;
    enable_wr = 1'b0;
    enable_rd = 1'b0;
    data_in   = 8'h00;

    // Reset then idle
    repeat (2) @(posedge wr_clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;
    step("idle", 1'b0, 1'b0, 8'h00);
    step("idle", 1'b0, 1'b0, 8'h00);

    // Fill, then a write into a full FIFO
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, fill_vals[i]);
    step("write_full", 1'b1, 1'b0, 8'h08);
    check("full_held", 32'(f_full), 32'd1);

    // Drain, with one extra read on empty
    for (int i = 0; i < 9; i++) step("drain", 1'b0, 1'b1, 8'h00);
    check("read_empty_hold", 32'(data_out), 32'h07);

    // Preload 3, then 10 cycles of simultaneous access across the wrap
    for (int i = 0; i < 3; i++) step("preload", 1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) step("simul", 1'b1, 1'b1, 8'(8'h23 + i));
    for (int i = 0; i < 3; i++) step("simul_drain", 1'b0, 1'b1, 8'h00);

    // Both enables on a full FIFO: only the read happens
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'(8'h50 + i));
    step("full_both", 1'b1, 1'b1, 8'hEE);
    check("full_both_not_full", 32'(f_full), 32'd0);
    check("full_both_data", 32'(data_out), 32'h50);

    // Both enables on an empty FIFO: only the write happens
    for (int i = 0; i < 7; i++) step("empty_out", 1'b0, 1'b1, 8'h00);
    step("empty_both", 1'b1, 1'b1, 8'h66);
    check("empty_both_not_empty", 32'(f_empty), 32'd0);
    check("empty_both_hold", 32'(data_out), 32'h57);
    step("empty_both_read", 1'b0, 1'b1, 8'h00);

    // Asynchronous reset pulse between edges mid-operation
    step("pre_rst_wr", 1'b1, 1'b0, 8'hBB);
    step("pre_rst_wr", 1'b1, 1'b0, 8'hBB);
    enable_wr = 1'b0;
    reset_n   = 1'b0;
    #2;
    q.delete();
    exp_dout = 8'h00;
    check_all("async_rst");
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst_wr", 1'b1, 1'b0, (i % 2 == 0) ? 8'hBB : 8'hBF);
    for (int i = 0; i < 5; i++) step("post_rst_rd", 1'b0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
